// File: rtl/mux16_scan_ctrl_if.sv
// Scan controller <-> mux tree / requester bundle. The parity wire exists only
// when SCAN_PARITY_EN is defined.
interface mux16_scan_ctrl_if #(
  parameter int NCH  = 16,
  parameter int SELW = 4
);
   logic            start;
   logic            mux_out;
   logic [SELW-1:0] sel;
   logic            busy;
   logic            done;
   logic [NCH-1:0]  word;
`ifdef SCAN_PARITY_EN
   logic            parity;

   modport slave  (input start, mux_out, output sel, busy, done, word, parity);
   modport master (output start, mux_out, input sel, busy, done, word, parity);
`else
   modport slave  (input start, mux_out, output sel, busy, done, word);
   modport master (output start, mux_out, input sel, busy, done, word);
`endif
endinterface

// File: rtl/mux16_scan_ctrl.sv
// Select sequencer for the 16:1 mux tree: walks sel over all channels, waits
// SETTLE cycles per channel, samples mux_out into a word. Option: SCAN_PARITY_EN.
module mux16_scan_ctrl #(
  parameter int NCH    = 16,
  parameter int SELW   = 4,
  parameter int SETTLE = 2
) (
   input logic              clk,
   input logic              rst,
   mux16_scan_ctrl_if.slave bus
);

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_e;

   localparam int              CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CW-1:0]   CNT_LOAD = (SETTLE > 0) ? CW'(SETTLE - 1) : '0;
   localparam state_e          S_NEXT   = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;
   localparam logic [SELW-1:0] CH_LAST  = SELW'(NCH - 1);

   state_e          state_q, state_d;
   logic [SELW-1:0] ch_q, ch_d;
   logic [SELW-1:0] sel_q, sel_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic [NCH-1:0]  word_q, word_d;
   logic [NCH-1:0]  shadow_q, shadow_d;
`ifdef SCAN_PARITY_EN
   logic            parity_q, parity_d;
`endif

   // NOTE: every _d starts from its hold value so no path leaves it unassigned (no latches).
   always_comb begin
      state_d  = state_q;
      ch_d     = ch_q;
      sel_d    = sel_q;
      cnt_d    = cnt_q;
      word_d   = word_q;
      shadow_d = shadow_q;
      done_d   = 1'b0;
`ifdef SCAN_PARITY_EN
      parity_d = parity_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               ch_d    = '0;
               sel_d   = '0;
               cnt_d   = CNT_LOAD;
               state_d = S_NEXT;
            end
         end
         S_SETTLE: begin
            if (cnt_q == '0) state_d = S_SAMPLE;
            else             cnt_d   = cnt_q - 1'b1;
         end
         S_SAMPLE: begin
            shadow_d[ch_q] = bus.mux_out;
            if (ch_q == CH_LAST) begin
               state_d = S_DONE;
            end else begin
               ch_d    = ch_q + 1'b1;
               sel_d   = ch_q + 1'b1;
               cnt_d   = CNT_LOAD;
               state_d = S_NEXT;
            end
         end
         S_DONE: begin
            // shadow_q already holds the last channel, sampled on entry to DONE
            word_d  = shadow_q;
            done_d  = 1'b1;
            sel_d   = '0;
            state_d = S_IDLE;
`ifdef SCAN_PARITY_EN
            parity_d = ^shadow_q;
`endif
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d == S_SETTLE) || (state_d == S_SAMPLE);
   end

   // NOTE: state registers use non-blocking assignments only; the shadow word is
   // a small flop vector and is cleared by reset along with everything else.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         ch_q     <= '0;
         sel_q    <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         word_q   <= '0;
         shadow_q <= '0;
`ifdef SCAN_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         ch_q     <= ch_d;
         sel_q    <= sel_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         word_q   <= word_d;
         shadow_q <= shadow_d;
`ifdef SCAN_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   assign bus.sel  = sel_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.word = word_q;
`ifdef SCAN_PARITY_EN
   assign bus.parity = parity_q;
`endif

endmodule

// File: tb/tb_mux16_scan_ctrl.sv
// Bench for mux16_scan_ctrl: two instances (SETTLE=0 and SETTLE=2), each fed by a
// behavioural 16:1 mux, checked against a timing/word model derived from the scan rules.
module tb_mux16_scan_ctrl;
   localparam int NCH = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // index 0: SETTLE=0 instance, index 1: SETTLE=2 instance
   logic        start_v[2];
   logic [15:0] a_v[2];
   logic [3:0]  sel_m[2];
   logic        busy_m[2];
   logic        done_m[2];
   logic [15:0] word_m[2];

   logic [15:0] exp_word[2];
   logic        exp_par[2];

   int errors = 0;
   int checks = 0;

   mux16_scan_ctrl_if #(.NCH(16), .SELW(4)) if0 ();
   mux16_scan_ctrl_if #(.NCH(16), .SELW(4)) if2 ();

   assign if0.start   = start_v[0];
   assign if2.start   = start_v[1];
   assign if0.mux_out = a_v[0][if0.sel];
   assign if2.mux_out = a_v[1][if2.sel];

   assign sel_m[0]  = if0.sel;   assign sel_m[1]  = if2.sel;
   assign busy_m[0] = if0.busy;  assign busy_m[1] = if2.busy;
   assign done_m[0] = if0.done;  assign done_m[1] = if2.done;
   assign word_m[0] = if0.word;  assign word_m[1] = if2.word;
`ifdef SCAN_PARITY_EN
   logic par_m[2];
   assign par_m[0] = if0.parity;
   assign par_m[1] = if2.parity;
`endif

   mux16_scan_ctrl #(.NCH(16), .SELW(4), .SETTLE(0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
   mux16_scan_ctrl #(.NCH(16), .SELW(4), .SETTLE(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One scan on instance d. A switches from a_old to a_new just after edge
   // k+change_j; start is re-pulsed after edge k+repulse_j (-1 = never).
   // With hold, start stays high and the task returns right after the done edge.
   task automatic run_scan(input int d, input logic [15:0] a_old, input logic [15:0] a_new,
                           input int change_j, input int repulse_j, input bit hold);
      int          s;
      int          l;
      int          last_j;
      logic [15:0] exp_w;
      logic [15:0] prev_w;
      s      = (d == 0) ? 0 : 2;
      l      = NCH * (s + 1) + 1;
      last_j = hold ? l : l + 1;
      prev_w = exp_word[d];
      exp_w  = '0;
      for (int i = 0; i < NCH; i++)
         exp_w[i] = (i * (s + 1) + s + 1 > change_j) ? a_new[i] : a_old[i];
      a_v[d]     = a_old;
      start_v[d] = 1'b1;
      tick();
      if (!hold) start_v[d] = 1'b0;
      for (int j = 0; j <= last_j; j++) begin
         if (j == change_j) a_v[d] = a_new;
         if (j == repulse_j) start_v[d] = 1'b1;
         if (j == repulse_j + 1) start_v[d] = 1'b0;

         checks++;
         if (done_m[d] !== (j == l)) begin
            errors++;
            $display("FAIL done d=%0d j=%0d: got %b want %b", d, j, done_m[d], (j == l));
         end
         checks++;
         if (busy_m[d] !== (j <= l - 2)) begin
            errors++;
            $display("FAIL busy d=%0d j=%0d: got %b want %b", d, j, busy_m[d], (j <= l - 2));
         end
         checks++;
         if (word_m[d] !== ((j >= l) ? exp_w : prev_w)) begin
            errors++;
            $display("FAIL word d=%0d j=%0d: got %h want %h", d, j, word_m[d],
                     (j >= l) ? exp_w : prev_w);
         end
         if (j <= l - 2) begin
            checks++;
            if (sel_m[d] !== 4'(j / (s + 1))) begin
               errors++;
               $display("FAIL sel d=%0d j=%0d: got %0d want %0d", d, j, sel_m[d], j / (s + 1));
            end
         end
`ifdef SCAN_PARITY_EN
         checks++;
         if (par_m[d] !== ((j >= l) ? ^exp_w : exp_par[d])) begin
            errors++;
            $display("FAIL parity d=%0d j=%0d: got %b want %b", d, j, par_m[d],
                     (j >= l) ? ^exp_w : exp_par[d]);
         end
`endif
         if (j < last_j) tick();
      end
      exp_word[d] = exp_w;
      exp_par[d]  = ^exp_w;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if ({sel_m[d], busy_m[d], done_m[d], word_m[d]} !== 23'd0) begin
            errors++;
            $display("FAIL reset d=%0d: got sel=%0d busy=%b done=%b word=%h want all zero",
                     d, sel_m[d], busy_m[d], done_m[d], word_m[d]);
         end
         exp_word[d] = '0;
         exp_par[d]  = 1'b0;
      end
   endtask

   task automatic test_basic();
      run_scan(1, 16'h3f0a, 16'h3f0a, -1, -1, 1'b0);
   endtask

   task automatic test_settle0();
      run_scan(0, 16'hA5C3, 16'hA5C3, -1, -1, 1'b0);
   endtask

   task automatic test_restart_ignored();
      // sel==5 on the SETTLE=2 instance spans offsets 15..17
      run_scan(1, 16'h5a3c, 16'h5a3c, -1, 15, 1'b0);
   endtask

   task automatic test_reset_mid();
      a_v[1]     = 16'hbeef;
      start_v[1] = 1'b1;
      tick();
      start_v[1] = 1'b0;
      for (int j = 0; j < 27; j++) tick();
      checks++;
      if (sel_m[1] !== 4'd9) begin
         errors++;
         $display("FAIL mid_sel: got %0d want 9", sel_m[1]);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int d = 0; d < 2; d++) begin
         exp_word[d] = '0;
         exp_par[d]  = 1'b0;
         checks++;
         if ({sel_m[d], busy_m[d], done_m[d], word_m[d]} !== 23'd0) begin
            errors++;
            $display("FAIL abort d=%0d: got sel=%0d busy=%b done=%b word=%h want all zero",
                     d, sel_m[d], busy_m[d], done_m[d], word_m[d]);
         end
      end
      for (int j = 0; j < 40; j++) begin
         tick();
         checks++;
         if (done_m[1] !== 1'b0 || busy_m[1] !== 1'b0) begin
            errors++;
            $display("FAIL abort_quiet j=%0d: got done=%b busy=%b want 0 0", j, done_m[1], busy_m[1]);
         end
      end
      run_scan(1, 16'h1234, 16'h1234, -1, -1, 1'b0);
   endtask

   task automatic test_back_to_back();
      run_scan(1, 16'h0001, 16'h0001, -1, -1, 1'b1);
      run_scan(1, 16'hFFFE, 16'hFFFE, -1, -1, 1'b0);
      run_scan(0, 16'h0001, 16'h0001, -1, -1, 1'b1);
      run_scan(0, 16'hFFFE, 16'hFFFE, -1, -1, 1'b0);
   endtask

   task automatic test_input_change();
      // change lands while sel==3 is settling; word must read FFF8
      run_scan(1, 16'h0000, 16'hFFFF, 9, -1, 1'b0);
      checks++;
      if (word_m[1] !== 16'hFFF8) begin
         errors++;
         $display("FAIL change_word: got %h want fff8", word_m[1]);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 4; n++) begin
         for (int d = 0; d < 2; d++) begin
            run_scan(d, 16'($urandom), 16'($urandom),
                     int'($urandom_range(0, (d == 0) ? 16 : 48)), -1, 1'b0);
         end
      end
   endtask

   initial begin
      rst        = 1'b1;
      start_v[0] = 1'b0;
      start_v[1] = 1'b0;
      a_v[0]     = '0;
      a_v[1]     = '0;
      test_reset();
      test_basic();
      test_settle0();
      test_restart_ignored();
      test_reset_mid();
      test_back_to_back();
      test_input_change();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
